// File: rtl/fp32_mul_arbiter_if.sv
// Requester / shared-multiplier bus for the FP32 mantissa multiplier arbiter.
// The master side is the PE-array fetch plus the datapath; the slave side is the arbiter.
interface fp32_mul_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 24
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          mul_valid;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [2*DATA_WIDTH-1:0]       mul_product;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [2*DATA_WIDTH-1:0]       resp_data;

    modport master (
        output req_valid, req_a, req_b, mul_product,
        input  req_ready, mul_valid, mul_a, mul_b, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_product,
        output req_ready, mul_valid, mul_a, mul_b, resp_valid, resp_data
    );
endinterface

// File: rtl/fp32_mul_arbiter.sv
// Round-robin scheduler sharing one fixed-latency mantissa multiplier among NUM_REQ requesters,
// with per-requester outstanding limits and an owner-tag pipeline to route products back.
module fp32_mul_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned LAT        = 3,
    parameter int unsigned MAX_OUT    = 2
) (
    input logic                clk,
    input logic                rst,
    fp32_mul_arbiter_if.slave  bus_io
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]         cnt_q [NUM_REQ];
    logic [CntW-1:0]         cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]      eligible, grant, issue;
    logic [PtrW-1:0]         grant_idx, scan_idx;
    logic                    grant_vld, hs;

    logic [LAT:0]            tag_vld_q;
    logic [PtrW-1:0]         tag_idx_q [LAT+1];

    logic                    mul_valid_q;
    logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [2*DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    // A retiring product frees its slot in the same cycle it is returned.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus_io.req_valid[i] &
                          ((cnt_q[i] < CntW'(MAX_OUT)) | resp_valid_q[i]);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PtrW'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant            = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    assign hs               = grant_vld & ~rst;
    assign issue            = grant & {NUM_REQ{hs}};
    assign bus_io.req_ready = rst ? '0 : grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        if (hs) begin
            rr_ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mul_a_d  = bus_io.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            mul_b_d  = bus_io.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        // Issue and retire in the same cycle cancel out.
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i] + CntW'(issue[i]) - CntW'(resp_valid_q[i]);
        end
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (tag_vld_q[LAT]) begin
            resp_valid_d = NUM_REQ'(1) << tag_idx_q[LAT];
            resp_data_d  = bus_io.mul_product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            mul_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
            for (int s = 0; s <= LAT; s++) tag_idx_q[s] <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mul_valid_q  <= hs;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
            // Stage 0 lines up with mul_valid; stage LAT with mul_product.
            tag_vld_q[0] <= hs;
            tag_idx_q[0] <= grant_idx;
            for (int s = 1; s <= LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign bus_io.mul_valid  = mul_valid_q;
    assign bus_io.mul_a      = mul_a_q;
    assign bus_io.mul_b      = mul_b_q;
    assign bus_io.resp_valid = resp_valid_q;
    assign bus_io.resp_data  = resp_data_q;
endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Randomized bench for fp32_mul_arbiter: a timestamped scoreboard of in-flight products
// predicts grants, multiplier issue and product returns cycle by cycle.
module tb_fp32_mul_arbiter;
    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 24;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXO = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_mul_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fp32_mul_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .LAT        (LAT),
        .MAX_OUT    (MAXO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    // Datapath stand-in: unsigned product of the registered operands, LAT cycles later.
    logic [2*DW-1:0] dp_q [LAT];
    always @(posedge clk) begin
        dp_q[0] <= (2*DW)'(bus.mul_a) * (2*DW)'(bus.mul_b);
        for (int k = 1; k < LAT; k++) dp_q[k] <= dp_q[k-1];
    end
    assign bus.mul_product = dp_q[LAT-1];

    typedef struct {
        int          due;
        int          idx;
        logic [47:0] prod;
    } pend_t;

    pend_t           pend[$];
    int              cyc = 0;
    int              rr_m = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    logic            exp_mul_valid = 1'b0;
    logic [DW-1:0]   exp_mul_a = '0;
    logic [DW-1:0]   exp_mul_b = '0;
    logic [NR-1:0]   exp_resp_valid;
    logic [2*DW-1:0] exp_resp_data = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grant, advance model.
    task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] a,
                        input logic [NR*DW-1:0] b, input logic r);
        int              g;
        int              outst;
        logic [NR-1:0]   exp_ready;
        logic [DW-1:0]   as, bs;
        exp_resp_valid = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                exp_resp_valid[pend[i].idx] = 1'b1;
                exp_resp_data = pend[i].prod;
            end
        end
        check_eq("mul_valid", 64'(bus.mul_valid), 64'(exp_mul_valid));
        check_eq("mul_a", 64'(bus.mul_a), 64'(exp_mul_a));
        check_eq("mul_b", 64'(bus.mul_b), 64'(exp_mul_b));
        check_eq("resp_valid", 64'(bus.resp_valid), 64'(exp_resp_valid));
        check_eq("resp_data", 64'(bus.resp_data), 64'(exp_resp_data));
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due < cyc) pend.delete(i);
        end

        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        rst           = r;
        #1;
        g = -1;
        if (!r) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (rr_m + k) % NR;
                outst = 0;
                foreach (pend[i]) if (pend[i].idx == j && pend[i].due > cyc) outst++;
                if (g < 0 && v[j] && outst < MAXO) g = j;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));

        if (r) begin
            pend.delete();
            rr_m          = 0;
            exp_mul_valid = 1'b0;
            exp_mul_a     = '0;
            exp_mul_b     = '0;
            exp_resp_data = '0;
        end else if (g >= 0) begin
            as = a[g*DW +: DW];
            bs = b[g*DW +: DW];
            pend.push_back('{due: cyc + int'(LAT) + 2, idx: g,
                             prod: (2*DW)'(as) * (2*DW)'(bs)});
            rr_m          = (g + 1) % NR;
            exp_mul_valid = 1'b1;
            exp_mul_a     = as;
            exp_mul_b     = bs;
        end else begin
            exp_mul_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [NR*DW-1:0] rand_ops();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, rand_ops(), rand_ops(), 1'b0);
    endtask

    task automatic hold(input logic [NR-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, rand_ops(), rand_ops(), 1'b0);
    endtask

    initial begin
        logic [NR*DW-1:0] a, b;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        @(posedge clk);
        #1;
        step('0, '0, '0, 1'b1);
        step(4'b1111, rand_ops(), rand_ops(), 1'b1);

        // Single request from requester 2: 1.0 x 1.0 mantissas.
        a = rand_ops();
        b = rand_ops();
        a[2*DW +: DW] = 24'h800000;
        b[2*DW +: DW] = 24'h800000;
        step(4'b0100, a, b, 1'b0);
        idle(4);
        check_eq("single_resp_valid", 64'(bus.resp_valid), 64'(4'b0100));
        check_eq("single_resp_data", 64'(bus.resp_data), 64'(48'h400000000000));
        idle(4);

        hold(4'b1111, 8);   // fairness
        idle(8);
        hold(4'b0001, 12);  // outstanding limit with same-cycle retire and issue
        idle(8);

        // Reset while three products are in flight.
        hold(4'b1111, 3);
        step(4'b1111, rand_ops(), rand_ops(), 1'b1);
        idle(8);
        hold(4'b1111, 2);
        idle(8);

        // Requester 1 full with rr_ptr at 1: requester 3 must be picked.
        hold(4'b0010, 2);
        hold(4'b0001, 1);
        hold(4'b1010, 1);
        idle(8);

        for (int n = 0; n < 800; n++) begin
            logic [NR-1:0] v;
            v = NR'($urandom) | NR'($urandom);
            step(v, rand_ops(), rand_ops(), ($urandom_range(0, 99) == 0));
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
